// File: rtl/lfsr_noise_arbiter_pkg.sv
// Shared constants, FSM state type and id-width helper for the LFSR noise arbiter.
package lfsr_noise_pkg;

  localparam int LFSR_W = 22;
  localparam int BLEN_W = 4;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  function automatic int id_width(input int n_req);
    return (n_req > 2) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/lfsr_noise_arbiter_if.sv
// Requester-facing bus of the LFSR noise arbiter: requests, grants and tagged samples.
interface lfsr_noise_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int LFSR_W = lfsr_noise_pkg::LFSR_W,
  parameter int BLEN_W = lfsr_noise_pkg::BLEN_W
);
  localparam int ID_W = lfsr_noise_pkg::id_width(N_REQ);

  logic        [N_REQ-1:0]        req;
  logic        [N_REQ*BLEN_W-1:0] burst_len;
  logic        [N_REQ-1:0]        gnt;
  logic                           out_valid;
  logic signed [LFSR_W-1:0]       out_data;
  logic        [ID_W-1:0]         out_id;
  logic        [N_REQ-1:0]        done;

  // Requester side
  modport master (
    output req, burst_len,
    input  gnt, out_valid, out_data, out_id, done
  );

  // Arbiter side
  modport slave (
    input  req, burst_len,
    output gnt, out_valid, out_data, out_id, done
  );
endinterface

// File: rtl/lfsr_noise_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  owner,
  output logic             any
);
  int idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    owner = rr_ptr;
    any   = 1'b0;
    idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        owner = ID_W'(idx);
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lfsr_noise_arbiter.sv
// Round-robin burst arbiter sharing one LFSR noise source; steps the LFSR once per delivered sample.
// Optional LFSR_STEP_CNT_EN adds a step counter (step_cnt) with a period-wrap pulse (step_wrap).
module lfsr_noise_arbiter #(
  parameter int N_REQ  = 4,
  parameter int LFSR_W = lfsr_noise_pkg::LFSR_W,
  parameter int BLEN_W = lfsr_noise_pkg::BLEN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  lfsr_noise_arbiter_if.slave      bus,
  input  logic                     sample_tick,
  input  logic                     resync,
  input  logic signed [LFSR_W-1:0] lfsr_y,
  output logic                     lfsr_clk_en,
  output logic                     lfsr_reset
`ifdef LFSR_STEP_CNT_EN
  ,
  output logic [LFSR_W-1:0]        step_cnt,
  output logic                     step_wrap
`endif
);
  import lfsr_noise_pkg::*;

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = BLEN_W + 1;
  localparam logic [CNT_W-1:0] FULL_BURST = {1'b1, {BLEN_W{1'b0}}};
  localparam logic [N_REQ-1:0] ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_t               state_q, state_d;
  logic [ID_W-1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                     resync_pend_q, resync_pend_d;
  logic [N_REQ-1:0]         gnt_q, gnt_d;
  logic                     apply_resync;

  logic                     vld_p0, vld_p1;
  logic signed [LFSR_W-1:0] out_data_p0, out_data_p1;
  logic [ID_W-1:0]          out_id_p0, out_id_p1;
  logic [N_REQ-1:0]         done_p0, done_p1;

  logic [ID_W-1:0]          pick_owner;
  logic                     pick_any;
  logic [BLEN_W-1:0]        pick_len;
  logic [ID_W-1:0]          next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .owner  (pick_owner),
    .any    (pick_any)
  );

  assign pick_len = bus.burst_len[pick_owner*BLEN_W +: BLEN_W];
  assign next_ptr = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    resync_pend_d = resync_pend_q | resync;
    gnt_d         = gnt_q;
    apply_resync  = 1'b0;
    lfsr_clk_en   = 1'b0;
    vld_p0        = 1'b0;
    out_data_p0   = out_data_p1;
    out_id_p0     = out_id_p1;
    done_p0       = '0;
    case (state_q)
      IDLE: begin
        // A pending resync takes the whole IDLE cycle; granting resumes on the next one.
        if (resync_pend_q) begin
          apply_resync  = 1'b1;
          resync_pend_d = resync;
        end else if (pick_any) begin
          owner_d = pick_owner;
          cnt_d   = (pick_len == '0) ? FULL_BURST : {1'b0, pick_len};
          gnt_d   = ONE_HOT0 << pick_owner;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!bus.req[owner_q]) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else if (sample_tick) begin
          // Capture the pre-step LFSR value on the same edge the LFSR advances.
          lfsr_clk_en = 1'b1;
          vld_p0      = 1'b1;
          out_data_p0 = lfsr_y;
          out_id_p0   = owner_q;
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            done_p0  = ONE_HOT0 << owner_q;
            gnt_d    = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lfsr_reset = reset | apply_resync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      resync_pend_q <= 1'b0;
      gnt_q         <= '0;
      vld_p1        <= 1'b0;
      out_data_p1   <= '0;
      out_id_p1     <= '0;
      done_p1       <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      resync_pend_q <= resync_pend_d;
      gnt_q         <= gnt_d;
      vld_p1        <= vld_p0;
      out_data_p1   <= out_data_p0;
      out_id_p1     <= out_id_p0;
      done_p1       <= done_p0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.out_id    = out_id_p1;
  assign bus.done      = done_p1;

`ifdef LFSR_STEP_CNT_EN
  // The LFSR period is 2**LFSR_W-1 states, so the count runs 0 .. 2**LFSR_W-2.
  localparam logic [LFSR_W-1:0] STEP_LAST = {{(LFSR_W-1){1'b1}}, 1'b0};

  logic [LFSR_W-1:0] step_cnt_q;
  logic              step_wrap_q;

  always_ff @(posedge clk) begin
    if (lfsr_reset) begin
      step_cnt_q  <= '0;
      step_wrap_q <= 1'b0;
    end else if (lfsr_clk_en) begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_q  <= '0;
        step_wrap_q <= 1'b1;
      end else begin
        step_cnt_q  <= step_cnt_q + 1'b1;
        step_wrap_q <= 1'b0;
      end
    end else begin
      step_wrap_q <= 1'b0;
    end
  end

  assign step_cnt  = step_cnt_q;
  assign step_wrap = step_wrap_q;
`endif

endmodule
